// File: rtl/sa_cache_mem_arbiter.sv
// Two-requester round-robin arbiter sharing one backing-memory port between
// cache controllers. A grant is held for the owner's whole miss sequence
// (write-back then allocate) and only drops when the owner lowers valid.
// Also provides saturating grant counters and a sticky stall watchdog.

// Per-requester saturating grant counter.
module sa_arb_grant_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Increment on grant, stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

module sa_cache_mem_arbiter #(
  parameter int ADDR_W         = 20,
  parameter int DATA_W         = 128,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_rw,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_rw,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              mem_valid,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              owner,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1,
  output logic              timeout_err
);
  localparam int NUM_REQ = 2;
  // Stall counter only needs to reach TIMEOUT_CYCLES; keep at least one bit.
  localparam int SW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [SW-1:0] TO_MAX = SW'(TIMEOUT_CYCLES);
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   rr_q, rr_d;
  logic [SW-1:0] stall_q, stall_d;
  logic   terr_q, terr_d;

  // Requester inputs gathered into packed arrays so the owner can index them.
  logic [NUM_REQ-1:0]             req_v, req_rw, req_rdy, gnt_inc;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0][CNT_W-1:0]  gcnt;

  assign req_v    = {req1_valid, req0_valid};
  assign req_rw   = {req1_rw,    req0_rw};
  assign req_addr = {req1_addr,  req0_addr};
  assign req_data = {req1_data,  req0_data};

  logic is_busy, own_v, gnt_id, any_req;
  assign is_busy = (state_q == BUSY);
  assign own_v   = req_v[owner_q];
  assign any_req = |req_v;
  // Contention goes to the round-robin pointer, otherwise to whoever asks.
  assign gnt_id  = (&req_v) ? rr_q : req_v[1];

  // Next-state: grant from IDLE, release when the owner drops valid.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    gnt_inc = '0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d          = BUSY;
          owner_d          = gnt_id;
          gnt_inc[gnt_id]  = 1'b1;
        end
      end
      BUSY: begin
        if (!own_v) begin
          state_d = IDLE;
          rr_d    = ~owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Watchdog: count owner stalls, clear on progress or on release.
  always_comb begin
    stall_d = '0;
    terr_d  = terr_q;
    if (is_busy && own_v && !mem_ready) begin
      stall_d = (stall_q == TO_MAX) ? stall_q : stall_q + 1'b1;
      if (WD_EN && (stall_d == TO_MAX)) terr_d = 1'b1;
    end
  end

  // State, ownership, pointer and watchdog registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      stall_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      stall_q <= stall_d;
      terr_q  <= terr_d;
    end
  end

  // Per-requester grant counter and ready routing.
  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_req
      sa_arb_grant_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (gnt_inc[g]),
        .cnt_o (gcnt[g])
      );
      assign req_rdy[g] = is_busy && (owner_q == 1'(g)) && mem_ready;
    end
  endgenerate

  // Memory port mirrors the owner while busy, quiet otherwise.
  assign mem_valid   = is_busy & own_v;
  assign mem_rw      = is_busy & req_rw[owner_q];
  assign mem_addr    = is_busy ? req_addr[owner_q] : '0;
  assign mem_data    = is_busy ? req_data[owner_q] : '0;

  assign req0_ready  = req_rdy[0];
  assign req1_ready  = req_rdy[1];
  assign rsp_data    = mem_rdata;
  assign busy        = is_busy;
  assign owner       = owner_q;
  assign grant_cnt0  = gcnt[0];
  assign grant_cnt1  = gcnt[1];
  assign timeout_err = terr_q;
endmodule

// File: doc/sa_cache_mem_arbiter.md
Name: sa_cache_mem_arbiter

Overview:
- Shares one backing-memory port between two set-associative cache controllers (e.g. I-cache and D-cache).
- Each requester drives a cache-to-memory request (valid/rw/addr/data) and samples memory ready/data.
- The block grants the port round-robin, keeps the grant across a requester's complete miss sequence (write-back followed by allocate), and routes ready only to the owner.
- Also provides grant counters and a memory-timeout watchdog.

Parameters:
- ADDR_W, 20, request address width (tag + index).
- DATA_W, 128, cache block width.
- CNT_W, 16, width of each saturating grant counter.
- TIMEOUT_CYCLES, 1024, stall cycles before timeout_err is raised; 0 disables the watchdog.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 memory request.
- req0_rw  in  1  requester 0: 1=write, 0=read.
- req0_addr  in  ADDR_W  requester 0 address.
- req0_data  in  DATA_W  requester 0 write data.
- req0_ready  out  1  memory ready routed to requester 0.
- req1_valid, req1_rw, req1_addr, req1_data, req1_ready: same as requester 0, for requester 1.
- mem_valid  out  1  request to memory.
- mem_rw  out  1  write/read to memory.
- mem_addr  out  ADDR_W  address to memory.
- mem_data  out  DATA_W  write data to memory.
- mem_ready  in  1  memory transfer complete.
- mem_rdata  in  DATA_W  memory read data.
- rsp_data  out  DATA_W  mem_rdata broadcast to both requesters.
- busy  out  1  port currently owned.
- owner  out  1  current/last owner index.
- grant_cnt0  out  CNT_W  grants issued to requester 0.
- grant_cnt1  out  CNT_W  grants issued to requester 1.
- timeout_err  out  1  sticky watchdog error.

Behaviour:
- FSM states: IDLE, BUSY. Registers: state, owner, rr_ptr (requester with priority), grant_cnt0/1, stall counter, timeout_err.
- Reset (asynchronous, rst=0), effective immediately, including mid-transaction:
  - state=IDLE, owner=0, rr_ptr=0, counters=0, timeout_err=0.
  - Hence mem_valid=0, mem_rw=0, mem_addr=0, mem_data=0, req0_ready=req1_ready=0, busy=0.
- IDLE:
  - Memory outputs are all zero. Both readies are 0.
  - If exactly one reqN_valid=1: next state BUSY, owner=N.
  - If both are valid: owner=rr_ptr.
  - The grant counter of the new owner increments, saturating at 2^CNT_W-1.
  - Grant latency: a request seen in cycle t produces mem_valid=1 in cycle t+1.
- BUSY:
  - mem_valid/rw/addr/data are combinationally muxed from the owner's request inputs.
  - req_owner_ready = mem_ready. The non-owner's ready is 0.
  - The grant is held while owner valid=1, including across mem_ready pulses. This lets a write-back to allocate sequence, or an rw change with valid held, complete without losing the port.
  - When owner valid=0: next state IDLE, rr_ptr = ~owner. In that cycle mem_valid=0 (mirrors the owner).
  - This gives one dead cycle between grants. The other requester, if waiting, is granted in the following IDLE cycle.
- The non-owner's requests are ignored (never forwarded) and need no ordering guarantee; requesters hold valid until served.
- rsp_data = mem_rdata at all times.
- busy = (state==BUSY).
- owner holds its value in IDLE.
- mem_ready while IDLE is ignored: no ready to either requester, no state change.
- Watchdog:
  - The stall counter increments each BUSY cycle with owner valid=1 and mem_ready=0.
  - It clears on mem_ready=1 or on leaving BUSY.
  - When the counter reaches TIMEOUT_CYCLES (non-zero), timeout_err is set. It is sticky until reset.
  - The grant is not revoked and the counter saturates.
- Counters never wrap.

Test Plan:
- Single requester: req0 read addr=0x00ABC. mem_valid rises 1 cycle later with mem_addr=0x00ABC, mem_rw=0. mem_ready after 3 cycles yields req0_ready=1 for exactly that cycle and req1_ready=0. grant_cnt0=1.
- Simultaneous request after reset: req0 and req1 valid in the same cycle. req0 is granted first (rr_ptr=0). After req0 drops valid there is one IDLE cycle, then req1 is granted. Next simultaneous pair grants req1 first? No: rr_ptr=0 after req1 completes, so req0 is granted first again.
- Miss with write-back: owner holds valid with rw=1, addr=0x3F001, then after mem_ready switches to rw=0, addr=0x01001. Grant persists, mem outputs follow the inputs, and req1 remains blocked throughout.
- Ready routing: while req1 owns the port, assert mem_ready. req0_ready stays 0. rsp_data equals mem_rdata=0xDEADBEEF... on both sides.
- Timeout: TIMEOUT_CYCLES=8, owner valid held, mem_ready=0. timeout_err=1 after the 8th stall cycle and stays 1 after a later mem_ready. Reset clears it.
- Reset mid-BUSY: drop rst asynchronously between clock edges. mem_valid, busy, and readies go to 0 immediately. After release the block returns to IDLE with counters at 0.
